adc_snapshot_ctrl: RTL and testbench
====================================

Name: adc_snapshot_ctrl

Overview:
Parametrised capture block between the analog core ADC outputs and the digital core. It merges the main and replica time-interleaved ADC lanes and converts them from sign-magnitude to two's complement. It stores the lanes in an on-chip snapshot buffer. Two capture modes are supported: one-shot, and a pre-trigger ring. After capture, the buffer is read back through a registered address port for JTAG/host dump.

Parameters:
N_MAIN, 16 (Nti), number of main ADC lanes
N_REP, 2 (Nti_rep), number of replica ADC lanes
ADC_W, 8 (Nadc), magnitude width per lane
DEPTH, 256, buffer words; power of two, >= 4
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk_adc  in  1  ADC retiming clock; the only clock
rst  in  1  synchronous, active-high reset
adcout  in  N_MAIN x ADC_W  main lane magnitudes
adcout_sign  in  N_MAIN  main lane signs
adcout_rep  in  N_REP x ADC_W  replica lane magnitudes
adcout_sign_rep  in  N_REP  replica lane signs
mode  in  1  0 = one-shot, 1 = pre-trigger ring
dump_start  in  1  trigger level; already synchronous to clk_adc
dump_clear  in  1  return to IDLE
post_count  in  AW  samples written after the trigger (mode 1)
rd_en  in  1  read strobe
rd_addr  in  AW  physical read address
rd_data  out  (N_MAIN+N_REP) x (ADC_W+1)  two's-complement word; main lanes at indices 0..N_MAIN-1, replica lanes above them
rd_valid  out  1  rd_data is valid
state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
done  out  1  state==DONE
full  out  1  ring has wrapped at least once
trig_addr  out  AW  address written in the trigger cycle

Behaviour:
- Clock and reset: single clock clk_adc. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, wr_ptr=0, cnt=0, done=0, full=0, trig_addr=0, rd_data=0, rd_valid=0, edge-detect register=0. Buffer contents are not reset.
- Conversion stage (1 cycle):
  - sign=1 gives +mag; sign=0 gives -mag, zero-extended to ADC_W+1 then negated.
  - sign=0 with mag=0 gives 0.
  - Lane word = {rep lanes, main lanes}, concatenated. The buffer writes the converted word one cycle after the ADC inputs.
- Trigger: trig = dump_start & ~dump_start_q. Only rising edges count.
- IDLE:
  - trig with mode=0: wr_ptr<=0, cnt<=DEPTH-1, trig_addr<=0, go to POST.
  - trig with mode=1: wr_ptr<=0, full<=0, go to ARMED.
  - No writes occur in IDLE.
- ARMED:
  - Write every cycle at wr_ptr; wr_ptr wraps DEPTH-1 -> 0. full<=1 on the first wrap.
  - On trig: the word is written at wr_ptr, trig_addr<=wr_ptr, cnt<=min(post_count, DEPTH-1) sampled this cycle.
  - If that cnt is 0, go to DONE; otherwise go to POST.
- POST:
  - Write at wr_ptr, wr_ptr++ with wrap, cnt--.
  - The write with cnt==0 is the last one; go to DONE.
  - Mode 0 therefore writes exactly DEPTH words, addresses 0..DEPTH-1.
- DONE:
  - No writes. Further trig is ignored.
  - rd_en=1 gives rd_data<=mem[rd_addr] and rd_valid=1 on the next cycle.
  - rd_en=0 gives rd_valid=0 next cycle; rd_data holds its value.
- Reads outside DONE: rd_valid=0 and rd_data holds.
- dump_clear: in any state, go to IDLE next cycle and clear done and rd_valid. Priority is rst > dump_clear > trig.
- rst in mid-capture: returns to IDLE immediately per the reset values. A capture is never resumed.
- mode is sampled only on the IDLE trig. Changes during a capture are ignored.
- Oldest sample in mode 1: (trig_addr+post_count+1) mod DEPTH when full=1. It is 0 when full=0. Host software computes this; no hardware reorder.

Decomposition:
- Add to const_pack (or a new snapshot_pack):
  - typedef enum logic[1:0] snap_state_t {IDLE, ARMED, POST, DONE}
  - signed lane typedef of ADC_W+1 bits
- One sub-module, adc_sm_to_tc: a single-lane sign-magnitude to two's-complement converter, registered. Instantiate it N_MAIN+N_REP times in a generate loop.
- The buffer is an inferred single-port array; writes and reads are mutually exclusive by state.

Test Plan:
- Reset, then mode=0 and a dump_start rise, with main lane 0 driven mag=5 sign=1 ramping by +1 per cycle -> done after DEPTH+1 cycles; rd_addr=0 returns lane0=+5; rd_addr=255 returns +260 truncated per ADC_W (lane0=+4 with 8 bits, wraps); rd_valid one cycle after rd_en.
- Sign conversion, lane values {mag=3,s=0}, {0,0}, {0,1}, {255,0} -> -3, 0, 0, -255 in 9-bit two's complement; replica lanes land at indices N_MAIN and above.
- Mode 1, arm, wait 300 cycles, trig with post_count=10 -> full=1, trig_addr=(300-1) mod 256 plus pipeline offset as counted on the bench, exactly 10 post writes, then done; the oldest-address formula reproduces the ramp in order.
- Mode 1, trig after 20 cycles with post_count=0 -> DONE next cycle, full=0, trig_addr=20±pipeline, word at trig_addr matches the trigger-cycle input.
- dump_start held high across IDLE->POST->DONE with no second edge -> stays in DONE; a second rise in DONE is ignored; dump_clear together with a rise -> IDLE, done=0.
- rst asserted mid-POST (cnt=100) -> next cycle state=0, rd_valid=0, trig_addr=0; a new one-shot capture completes normally.

Source files
------------

// File: rtl/adc_snapshot_ctrl_pkg.sv
// Shared types for the ADC snapshot capture block: FSM state encoding and
// the default-width signed lane type used when dumping captured words.
package adc_snapshot_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } snap_state_t;

   localparam int LANE_ADC_W = 8;

   // One converted lane at the default ADC width (magnitude plus sign bit).
   typedef logic signed [LANE_ADC_W:0] snap_lane_t;

endpackage

// File: rtl/adc_sm_to_tc.sv
// Single-lane sign-magnitude to two's-complement converter, one register stage.
// sign=1 means positive; a negative zero collapses to zero.
module adc_sm_to_tc #(
   parameter int ADC_W = 8
) (
   input  logic             clk_adc,
   input  logic             rst,
   input  logic [ADC_W-1:0] mag,
   input  logic             sign,
   output logic [ADC_W:0]   tc
);

   logic [ADC_W:0] mag_ext_s;
   logic [ADC_W:0] tc_d;
   logic [ADC_W:0] tc_q;

   // Widen first so the largest magnitude still negates without overflow.
   always_comb begin
      mag_ext_s = {1'b0, mag};
      if (sign) begin
         tc_d = mag_ext_s;
      end else begin
         tc_d = -mag_ext_s;
      end
   end

   // Conversion pipeline register.
   always_ff @(posedge clk_adc) begin
      if (rst) begin
         tc_q <= {(ADC_W+1){1'b0}};
      end else begin
         tc_q <= tc_d;
      end
   end

   assign tc = tc_q;

endmodule

// File: rtl/adc_snapshot_ctrl.sv
// Snapshot capture of main + replica ADC lanes into an on-chip buffer, with
// one-shot and pre-trigger ring modes and a registered read-back port.
module adc_snapshot_ctrl
   import adc_snapshot_ctrl_pkg::*;
#(
   parameter  int N_MAIN = 16,
   parameter  int N_REP  = 2,
   parameter  int ADC_W  = 8,
   parameter  int DEPTH  = 256,
   localparam int AW     = $clog2(DEPTH),
   localparam int LW     = ADC_W + 1,
   localparam int WW     = (N_MAIN + N_REP) * LW
) (
   input  logic                    clk_adc,
   input  logic                    rst,
   input  logic [N_MAIN*ADC_W-1:0] adcout,
   input  logic [N_MAIN-1:0]       adcout_sign,
   input  logic [N_REP*ADC_W-1:0]  adcout_rep,
   input  logic [N_REP-1:0]        adcout_sign_rep,
   input  logic                    mode,
   input  logic                    dump_start,
   input  logic                    dump_clear,
   input  logic [AW-1:0]           post_count,
   input  logic                    rd_en,
   input  logic [AW-1:0]           rd_addr,
   output logic [WW-1:0]           rd_data,
   output logic                    rd_valid,
   output logic [1:0]              state,
   output logic                    done,
   output logic                    full,
   output logic [AW-1:0]           trig_addr
);

   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

   logic [WW-1:0] conv_word_s;
   logic [WW-1:0] mem [DEPTH];

   snap_state_t   state_d, state_q;
   logic [AW-1:0] wr_ptr_d, wr_ptr_q;
   logic [AW-1:0] cnt_d, cnt_q;
   logic [AW-1:0] trig_addr_d, trig_addr_q;
   logic          full_d, full_q;
   logic          done_d, done_q;
   logic          mode_d, mode_q;
   logic          dump_start_q;
   logic [WW-1:0] rd_data_d, rd_data_q;
   logic          rd_valid_d, rd_valid_q;
   logic          trig_s;
   logic          wr_en_s;

   genvar gi;
   generate
      for (gi = 0; gi < N_MAIN; gi++) begin : g_main
         adc_sm_to_tc #(.ADC_W(ADC_W)) u_conv (
            .clk_adc (clk_adc),
            .rst     (rst),
            .mag     (adcout[gi*ADC_W +: ADC_W]),
            .sign    (adcout_sign[gi]),
            .tc      (conv_word_s[gi*LW +: LW])
         );
      end
      for (gi = 0; gi < N_REP; gi++) begin : g_rep
         adc_sm_to_tc #(.ADC_W(ADC_W)) u_conv (
            .clk_adc (clk_adc),
            .rst     (rst),
            .mag     (adcout_rep[gi*ADC_W +: ADC_W]),
            .sign    (adcout_sign_rep[gi]),
            .tc      (conv_word_s[(N_MAIN+gi)*LW +: LW])
         );
      end
   endgenerate

   // Capture FSM next-state, write control and read-back mux.
   always_comb begin
      trig_s      = dump_start & ~dump_start_q;
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q;
      trig_addr_d = trig_addr_q;
      full_d      = full_q;
      mode_d      = mode_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      wr_en_s     = 1'b0;

      if (dump_clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (trig_s) begin
                  wr_ptr_d = PTR_ZERO;
                  mode_d   = mode;
                  if (mode) begin
                     full_d  = 1'b0;
                     state_d = ARMED;
                  end else begin
                     cnt_d       = PTR_LAST;
                     trig_addr_d = PTR_ZERO;
                     state_d     = POST;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            ARMED: begin
               wr_en_s  = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_ONE;
               if (wr_ptr_q == PTR_LAST) begin
                  full_d = 1'b1;
               end else begin
                  full_d = full_q;
               end
               // The trigger word itself is the last pre-trigger sample; cnt
               // then holds (post writes remaining - 1) so POST ends on cnt==0.
               if (trig_s) begin
                  trig_addr_d = wr_ptr_q;
                  if (post_count == PTR_ZERO) begin
                     state_d = DONE;
                  end else begin
                     cnt_d   = post_count - PTR_ONE;
                     state_d = POST;
                  end
               end else begin
                  state_d = ARMED;
               end
            end
            POST: begin
               wr_en_s  = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_ONE;
               cnt_d    = cnt_q - PTR_ONE;
               if (mode_q && (wr_ptr_q == PTR_LAST)) begin
                  full_d = 1'b1;
               end else begin
                  full_d = full_q;
               end
               if (cnt_q == PTR_ZERO) begin
                  state_d = DONE;
               end else begin
                  state_d = POST;
               end
            end
            DONE: begin
               if (rd_en) begin
                  rd_data_d  = mem[rd_addr];
                  rd_valid_d = 1'b1;
               end else begin
                  rd_valid_d = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      done_d = (state_d == DONE);
   end

   // Control and output registers.
   always_ff @(posedge clk_adc) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= PTR_ZERO;
         cnt_q        <= PTR_ZERO;
         trig_addr_q  <= PTR_ZERO;
         full_q       <= 1'b0;
         done_q       <= 1'b0;
         mode_q       <= 1'b0;
         dump_start_q <= 1'b0;
         rd_data_q    <= {WW{1'b0}};
         rd_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         cnt_q        <= cnt_d;
         trig_addr_q  <= trig_addr_d;
         full_q       <= full_d;
         done_q       <= done_d;
         mode_q       <= mode_d;
         dump_start_q <= dump_start;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
      end
   end

   // Snapshot buffer write port; contents are deliberately not reset.
   always_ff @(posedge clk_adc) begin
      if (wr_en_s) begin
         mem[wr_ptr_q] <= conv_word_s;
      end
   end

   assign state     = state_q;
   assign done      = done_q;
   assign full      = full_q;
   assign trig_addr = trig_addr_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_adc_snapshot_ctrl.sv
// Directed self-checking bench for adc_snapshot_ctrl: one-shot capture, sign
// conversion, pre-trigger ring, post_count=0, trigger edge rules and reset.
module tb_adc_snapshot_ctrl;

   localparam int N_MAIN = 16;
   localparam int N_REP  = 2;
   localparam int ADC_W  = 8;
   localparam int DEPTH  = 256;
   localparam int AW     = 8;
   localparam int LW     = 9;
   localparam int NL     = N_MAIN + N_REP;
   localparam int WW     = NL * LW;

   logic                    clk_adc = 1'b0;
   logic                    rst;
   logic [N_MAIN*ADC_W-1:0] adcout;
   logic [N_MAIN-1:0]       adcout_sign;
   logic [N_REP*ADC_W-1:0]  adcout_rep;
   logic [N_REP-1:0]        adcout_sign_rep;
   logic                    mode;
   logic                    dump_start;
   logic                    dump_clear;
   logic [AW-1:0]           post_count;
   logic                    rd_en;
   logic [AW-1:0]           rd_addr;
   logic [WW-1:0]           rd_data;
   logic                    rd_valid;
   logic [1:0]              state;
   logic                    done;
   logic                    full;
   logic [AW-1:0]           trig_addr;

   logic [ADC_W-1:0] mag [NL];
   logic             sgn [NL];
   int               ramp;
   bit               ramp_on;
   int               total = 0;
   int               bad   = 0;
   logic [WW-1:0]    exp_word;

   always #5 clk_adc = ~clk_adc;

   adc_snapshot_ctrl dut (
      .clk_adc         (clk_adc),
      .rst             (rst),
      .adcout          (adcout),
      .adcout_sign     (adcout_sign),
      .adcout_rep      (adcout_rep),
      .adcout_sign_rep (adcout_sign_rep),
      .mode            (mode),
      .dump_start      (dump_start),
      .dump_clear      (dump_clear),
      .post_count      (post_count),
      .rd_en           (rd_en),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data),
      .rd_valid        (rd_valid),
      .state           (state),
      .done            (done),
      .full            (full),
      .trig_addr       (trig_addr)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N_MAIN; i++) begin
         adcout[i*ADC_W +: ADC_W] = mag[i];
         adcout_sign[i]           = sgn[i];
      end
      for (int j = 0; j < N_REP; j++) begin
         adcout_rep[j*ADC_W +: ADC_W] = mag[N_MAIN+j];
         adcout_sign_rep[j]           = sgn[N_MAIN+j];
      end
   endtask

   task automatic clear_lanes();
      for (int i = 0; i < NL; i++) begin
         mag[i] = 8'd0;
         sgn[i] = 1'b1;
      end
      apply();
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_adc);
         #1;
         if (ramp_on) begin
            ramp   = ramp + 1;
            mag[0] = ramp[7:0];
         end
         apply();
      end
   endtask

   task automatic set_ramp(input int v);
      ramp    = v;
      mag[0]  = ramp[7:0];
      sgn[0]  = 1'b1;
      ramp_on = 1'b1;
      apply();
   endtask

   task automatic read_lane0(input string tag, input int addr, input int val);
      logic [8:0] e;
      e       = 9'(val & 255);
      rd_en   = 1'b1;
      rd_addr = AW'(addr);
      tick(1);
      chk(tag, rd_data[LW-1:0], e);
      rd_en = 1'b0;
   endtask

   task automatic go_idle();
      dump_clear = 1'b1;
      dump_start = 1'b0;
      tick(1);
      dump_clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; dump_start = 1'b0; dump_clear = 1'b0;
      post_count = 8'd0; rd_en = 1'b0; rd_addr = 8'd0;
      ramp = 0; ramp_on = 1'b0;
      clear_lanes();
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_state", state, 2'd0);
      chk("rst_done", done, 1'b0);
      chk("rst_full", full, 1'b0);
      chk("rst_trig_addr", trig_addr, 8'd0);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_rd_data", rd_data, 162'd0);

      // One-shot capture, lane0 ramps from 5; dump_start stays high throughout.
      set_ramp(5);
      mode = 1'b0;
      dump_start = 1'b1;
      tick(1);
      chk("os_post", state, 2'd2);
      tick(255);
      chk("os_not_done", done, 1'b0);
      tick(1);
      chk("os_done", done, 1'b1);
      chk("os_state_done", state, 2'd3);
      ramp_on = 1'b0;
      rd_en = 1'b1; rd_addr = 8'd0;
      chk("rd_valid_before", rd_valid, 1'b0);
      tick(1);
      chk("rd_valid_after", rd_valid, 1'b1);
      chk("os_addr0", rd_data[LW-1:0], 9'd5);
      rd_addr = 8'd255;
      tick(1);
      chk("os_addr255", rd_data[LW-1:0], 9'd4);
      rd_en = 1'b0;
      tick(1);
      chk("rd_valid_drop", rd_valid, 1'b0);
      chk("rd_data_hold", rd_data[LW-1:0], 9'd4);

      // Trigger edge rules in DONE, then dump_clear beats a simultaneous rise.
      chk("held_high_done", state, 2'd3);
      dump_start = 1'b0; tick(1);
      dump_start = 1'b1; tick(1);
      chk("rise_in_done_ignored", state, 2'd3);
      dump_start = 1'b0; tick(1);
      dump_start = 1'b1; dump_clear = 1'b1; tick(1);
      chk("clear_wins_state", state, 2'd0);
      chk("clear_wins_done", done, 1'b0);
      dump_clear = 1'b0; tick(1);
      chk("no_edge_stays_idle", state, 2'd0);

      // Sign conversion, including replica lanes above the main lanes.
      dump_start = 1'b0; tick(1);
      clear_lanes();
      mag[0] = 8'd3;   sgn[0] = 1'b0;
      mag[1] = 8'd0;   sgn[1] = 1'b0;
      mag[2] = 8'd0;   sgn[2] = 1'b1;
      mag[3] = 8'd255; sgn[3] = 1'b0;
      mag[N_MAIN]   = 8'd7;   sgn[N_MAIN]   = 1'b1;
      mag[N_MAIN+1] = 8'd200; sgn[N_MAIN+1] = 1'b0;
      apply();
      mode = 1'b0; dump_start = 1'b1;
      tick(257);
      chk("sc_done", state, 2'd3);
      exp_word = {WW{1'b0}};
      exp_word[0*LW +: LW]          = 9'h1FD;
      exp_word[3*LW +: LW]          = 9'h101;
      exp_word[N_MAIN*LW +: LW]     = 9'h007;
      exp_word[(N_MAIN+1)*LW +: LW] = 9'h138;
      rd_en = 1'b1; rd_addr = 8'd10;
      tick(1);
      rd_en = 1'b0;
      chk("sc_word", rd_data, exp_word);
      chk("sc_rep1", rd_data[(N_MAIN+1)*LW +: LW], 9'h138);

      // Pre-trigger ring: arm, trigger 300 cycles later, 10 post samples.
      go_idle();
      clear_lanes();
      set_ramp(100);
      mode = 1'b1; post_count = 8'd10; dump_start = 1'b1;
      tick(1);
      chk("ring_armed", state, 2'd1);
      dump_start = 1'b0;
      mode = 1'b0;
      tick(299);
      chk("ring_still_armed", state, 2'd1);
      chk("ring_full", full, 1'b1);
      dump_start = 1'b1;
      tick(1);
      chk("ring_trig_addr", trig_addr, 8'd43);
      chk("ring_post", state, 2'd2);
      tick(9);
      chk("ring_post_9", state, 2'd2);
      tick(1);
      chk("ring_done", state, 2'd3);
      dump_start = 1'b0;
      ramp_on = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         read_lane0("ring_order", (43 + 10 + 1 + i) % DEPTH, 154 + i);
      end

      // Ring with post_count=0 before any wrap.
      go_idle();
      set_ramp(0);
      mode = 1'b1; post_count = 8'd0; dump_start = 1'b1;
      tick(1);
      dump_start = 1'b0;
      rd_en = 1'b1; rd_addr = 8'd0;
      tick(19);
      chk("pc0_armed", state, 2'd1);
      chk("rd_valid_outside_done", rd_valid, 1'b0);
      rd_en = 1'b0;
      dump_start = 1'b1;
      tick(1);
      chk("pc0_done", state, 2'd3);
      chk("pc0_full", full, 1'b0);
      chk("pc0_trig_addr", trig_addr, 8'd19);
      dump_start = 1'b0;
      ramp_on = 1'b0;
      read_lane0("pc0_word", 19, 19);

      // Reset in the middle of a long post-trigger phase, then a fresh one-shot.
      go_idle();
      set_ramp(0);
      mode = 1'b1; post_count = 8'd200; dump_start = 1'b1;
      tick(1);
      dump_start = 1'b0;
      tick(19);
      dump_start = 1'b1;
      tick(1);
      chk("mid_trig_addr", trig_addr, 8'd19);
      dump_start = 1'b0;
      tick(99);
      chk("mid_post", state, 2'd2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("mid_rst_state", state, 2'd0);
      chk("mid_rst_trig_addr", trig_addr, 8'd0);
      chk("mid_rst_rd_valid", rd_valid, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      set_ramp(50);
      mode = 1'b0; dump_start = 1'b1;
      tick(257);
      chk("re_done", done, 1'b1);
      ramp_on = 1'b0;
      read_lane0("re_addr0", 0, 50);
      read_lane0("re_addr100", 100, 150);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
